fetch_stage: RTL and testbench

- IF stage of the 16-bit pipeline. It owns the PC register, fetches through a req/rdy handshake to the instruction cache/memory, and loads the IF/ID pipeline register.
- It sits directly upstream of the branch/PC-control logic. It supplies the PC of each fetched instruction (if_id_pc) and consumes branch_taken/branch_target from that logic.
- It absorbs variable memory latency, hazard stalls, branch flushes and HLT detection.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a req/rdy handshake and loads the IF/ID register.
// Absorbs memory wait states, hazard stalls (via a one-entry skid buffer), branch flushes and HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_out,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fetch_halted
);

    typedef enum logic [1:0] {StFetch, StDiscard, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        halted_q, halted_d;

    logic        take;
    logic [15:0] take_instr;
    logic        flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            if_instr_q  <= NOP_INSTR;
            if_pc_q     <= 16'h0000;
            if_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_valid_q  <= if_valid_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        halted_d    = halted_q;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        take        = 1'b0;
        take_instr  = imem_data;
        flush       = 1'b0;

        unique case (state_q)
            StFetch: begin
                // rst_n gate keeps req low while reset is held
                imem_req   = rst_n & ~buf_valid_q;
                req_addr_d = pc_q;
                if (stall) begin
                    if (imem_req && imem_rdy) begin
                        buf_valid_d = 1'b1;
                        buf_instr_d = imem_data;
                    end
                end else if (branch_taken) begin
                    flush = 1'b1;
                    if (imem_req && !imem_rdy) state_d = StDiscard;
                end else if (buf_valid_q) begin
                    take        = 1'b1;
                    take_instr  = buf_instr_q;
                    buf_valid_d = 1'b0;
                end else if (imem_req && imem_rdy) begin
                    take = 1'b1;
                end
            end
            StDiscard: begin
                // Old request must complete at its original address; its data is dropped
                imem_req  = rst_n;
                imem_addr = req_addr_q;
                if (!stall && branch_taken) pc_d = branch_target;
                if (imem_rdy) state_d = StFetch;
            end
            StHalted: begin
                if (!stall && branch_taken) begin
                    flush   = 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (flush) begin
            pc_d        = branch_target;
            if_valid_d  = 1'b0;
            if_instr_d  = NOP_INSTR;
            buf_valid_d = 1'b0;
            halted_d    = 1'b0;
        end

        if (take) begin
            if_instr_d = take_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (take_instr[15:12] == HALT_OPCODE) begin
                state_d  = StHalted;
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + 16'd2;
            end
        end
    end

    assign pc_out       = pc_q;
    assign if_id_instr  = if_instr_q;
    assign if_id_pc     = if_pc_q;
    assign if_id_valid  = if_valid_q;
    assign fetch_halted = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios followed by randomized traffic against a transaction-level model of the IF stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] pc_out;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_halted;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdy     (imem_rdy),
        .imem_data    (imem_data),
        .pc_out       (pc_out),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .fetch_halted (fetch_halted)
    );

    always #5 clk = ~clk;

    // Reference model: what the stage has delivered and what it is waiting on
    logic [15:0] m_pc, m_ii, m_ipc, m_daddr, m_binstr;
    logic        m_iv, m_halt, m_disc, m_buf;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [15:0] t, input logic r,
                        input logic [15:0] d);
        stall = s; branch_taken = b; branch_target = t; imem_rdy = r; imem_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_ii = 16'h0000; m_ipc = 16'h0000; m_iv = 1'b0;
        m_halt = 1'b0; m_disc = 1'b0; m_daddr = 16'h0000; m_buf = 1'b0; m_binstr = 16'h0000;
    endtask

    function automatic logic m_req();
        return !m_halt && (m_disc || !m_buf);
    endfunction

    task automatic deliver(input logic [15:0] i);
        m_ii = i; m_ipc = m_pc; m_iv = 1'b1;
        if (i[15:12] == 4'hF) m_halt = 1'b1;
        else m_pc = m_pc + 16'd2;
    endtask

    task automatic redirect(input logic [15:0] t);
        m_pc = t; m_iv = 1'b0; m_ii = 16'h0000; m_buf = 1'b0; m_halt = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [15:0] t, input logic r,
                              input logic [15:0] d);
        logic req;
        req = m_req();
        if (m_halt) begin
            if (!s && b) redirect(t);
        end else if (m_disc) begin
            if (!s && b) m_pc = t;
            if (r) m_disc = 1'b0;
        end else if (s) begin
            if (req && r) begin m_buf = 1'b1; m_binstr = d; end
        end else if (b) begin
            if (req && !r) begin m_disc = 1'b1; m_daddr = m_pc; end
            redirect(t);
        end else if (m_buf) begin
            m_buf = 1'b0;
            deliver(m_binstr);
        end else if (req && r) begin
            deliver(d);
        end
    endtask

    task automatic compare_model();
        chk("rnd_req", {15'd0, imem_req}, {15'd0, m_req()});
        if (m_req()) chk("rnd_addr", imem_addr, m_disc ? m_daddr : m_pc);
        chk("rnd_pc", pc_out, m_pc);
        chk("rnd_valid", {15'd0, if_id_valid}, {15'd0, m_iv});
        chk("rnd_instr", if_id_instr, m_ii);
        if (m_iv) chk("rnd_ifpc", if_id_pc, m_ipc);
        chk("rnd_halt", {15'd0, fetch_halted}, {15'd0, m_halt});
    endtask

    initial begin
        logic        s, b, r, pend;
        logic [15:0] t, d, tmp;
        int          lat;

        // Reset values
        #3;
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_ifpc", if_id_pc, 16'h0000);
        chk("rst_halt", {15'd0, fetch_halted}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req", {15'd0, imem_req}, 16'd1);
        chk("first_addr", imem_addr, 16'h0000);

        // Zero-wait memory, two back-to-back accepts
        step(0, 0, 16'h0, 1, 16'h1234);
        chk("zw1_valid", {15'd0, if_id_valid}, 16'd1);
        chk("zw1_instr", if_id_instr, 16'h1234);
        chk("zw1_ifpc", if_id_pc, 16'h0000);
        chk("zw1_addr", imem_addr, 16'h0002);
        step(0, 0, 16'h0, 1, 16'h2345);
        chk("zw2_instr", if_id_instr, 16'h2345);
        chk("zw2_ifpc", if_id_pc, 16'h0002);
        chk("zw2_pc", pc_out, 16'h0004);

        // Wait states with a branch mid-request: old address held, data dropped
        step(0, 0, 16'h0, 0, 16'h0);
        step(0, 1, 16'h0040, 0, 16'h0);
        chk("br_valid", {15'd0, if_id_valid}, 16'd0);
        chk("br_req", {15'd0, imem_req}, 16'd1);
        chk("br_addr_old", imem_addr, 16'h0004);
        chk("br_pc", pc_out, 16'h0040);
        step(0, 0, 16'h0, 1, 16'h5555);
        chk("br_drop_valid", {15'd0, if_id_valid}, 16'd0);
        chk("br_new_addr", imem_addr, 16'h0040);
        chk("br_new_req", {15'd0, imem_req}, 16'd1);

        // Stall with data arriving in the first stall cycle goes to the skid buffer
        step(1, 0, 16'h0, 1, 16'hABCD);
        chk("stl_req", {15'd0, imem_req}, 16'd0);
        chk("stl_valid", {15'd0, if_id_valid}, 16'd0);
        step(1, 0, 16'h0, 1, 16'hEEEE);
        step(1, 0, 16'h0, 0, 16'h0);
        step(1, 0, 16'h0, 0, 16'h0);
        chk("stl_req4", {15'd0, imem_req}, 16'd0);
        chk("stl_pc", pc_out, 16'h0040);
        step(0, 0, 16'h0, 1, 16'h7777);
        chk("stl_rel_instr", if_id_instr, 16'hABCD);
        chk("stl_rel_ifpc", if_id_pc, 16'h0040);
        chk("stl_rel_pc", pc_out, 16'h0042);
        chk("stl_rel_req", {15'd0, imem_req}, 16'd1);

        // HLT at 0x0010: fetching stops until a branch
        step(0, 1, 16'h0010, 0, 16'h0);
        step(0, 0, 16'h0, 1, 16'h0);
        chk("hlt_addr", imem_addr, 16'h0010);
        step(0, 0, 16'h0, 1, 16'hF000);
        for (int i = 0; i < 10; i++) begin
            chk("hlt_flag", {15'd0, fetch_halted}, 16'd1);
            chk("hlt_req", {15'd0, imem_req}, 16'd0);
            chk("hlt_pc", pc_out, 16'h0010);
            chk("hlt_instr", if_id_instr, 16'hF000);
            step(1'($urandom_range(0, 1)), 0, 16'h0, 1'($urandom_range(0, 1)), 16'h1111);
        end
        step(0, 1, 16'h0100, 0, 16'h0);
        chk("hlt_exit_flag", {15'd0, fetch_halted}, 16'd0);
        chk("hlt_exit_req", {15'd0, imem_req}, 16'd1);
        chk("hlt_exit_addr", imem_addr, 16'h0100);

        // Branch with same-cycle rdy, then PC wrap at 0xFFFE
        step(0, 1, 16'hFFFE, 1, 16'h3333);
        chk("wrap_valid", {15'd0, if_id_valid}, 16'd0);
        chk("wrap_addr0", imem_addr, 16'hFFFE);
        step(0, 0, 16'h0, 1, 16'h1111);
        chk("wrap_ifpc", if_id_pc, 16'hFFFE);
        chk("wrap_addr", imem_addr, 16'h0000);

        // Reset pulsed mid-request
        step(0, 0, 16'h0, 1, 16'h2222);
        step(0, 0, 16'h0, 0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req", {15'd0, imem_req}, 16'd0);
        chk("mrst_valid", {15'd0, if_id_valid}, 16'd0);
        chk("mrst_instr", if_id_instr, 16'h0000);
        chk("mrst_ifpc", if_id_pc, 16'h0000);
        chk("mrst_pc", pc_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_first_req", {15'd0, imem_req}, 16'd1);
        chk("mrst_first_addr", imem_addr, 16'h0000);

        // Randomized traffic against the model
        model_reset();
        pend = 1'b0;
        lat = 0;
        for (int c = 0; c < 400; c++) begin
            compare_model();
            s = ($urandom_range(0, 4) == 0);
            b = !s && ($urandom_range(0, 7) == 0);
            tmp = 16'($urandom);
            t = {tmp[15:1], 1'b0};
            d = 16'($urandom);
            if (m_req()) begin
                if (!pend) begin
                    pend = 1'b1;
                    lat = $urandom_range(0, 3);
                end
                r = (lat == 0);
                if (r) pend = 1'b0;
                else lat--;
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            stall = s; branch_taken = b; branch_target = t; imem_rdy = r; imem_data = d;
            @(posedge clk);
            model_step(s, b, t, r, d);
            #1;
        end
        compare_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
